// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared state encoding and framing constants for the cassette playback engine
package tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP,
        LEADER
    } tape_state_t;

    localparam int LEADER_BITS   = 256;
    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/tape_bitcell.sv
// rtl/tape_bitcell.sv - one square cycle per bit: high for H ticks, low for H ticks, done on the last tick
module tape_bitcell #(
    parameter int HALF_W = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              hold,
    input  logic              start,
    input  logic              bit_val,
    input  logic [HALF_W-1:0] one_half,
    input  logic [HALF_W-1:0] zero_half,
    output logic              out,
    output logic              done
);

    logic [HALF_W-1:0] half;
    logic [HALF_W:0]   cnt;
    logic [HALF_W:0]   last;
    logic              tick;

    assign half = bit_val ? one_half : zero_half;
    assign last = {half, 1'b0} - (HALF_W+1)'(1);
    assign tick = ce && !hold && !start;
    assign done = tick && (cnt == last);

    // The counter self-restarts after the last tick so back-to-back cells lose no time.
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (tick) begin
            out <= (cnt < {1'b0, half});
            cnt <= (cnt == last) ? '0 : cnt + (HALF_W+1)'(1);
        end
    end

endmodule

// File: rtl/tape_player.sv
// rtl/tape_player.sv - CAQ tape image playback into the 1-bit cassette waveform; TAPE_LEADER_EN adds a 256-cell leader
module tape_player
    import tape_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int HALF_W    = 4,
    parameter int ONE_HALF  = 1,
    parameter int ZERO_HALF = 2,
    parameter int STOP_BITS = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_tape,
    input  logic              loaded,
    input  logic [ADDR_W-1:0] length,
    input  logic              pause,
    input  logic              rewind,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              req,
    output logic              out,
    output logic [ADDR_W-1:0] progress
);

`ifdef TAPE_LEADER_EN
    localparam tape_state_t FIRST_STATE = LEADER;
    logic [7:0] leader_cnt;
`else
    localparam tape_state_t FIRST_STATE = FETCH;
`endif

    tape_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic [1:0]        stop_cnt;
    logic              in_cell;
    logic              cell_bit;
    logic              cell_start;
    logic              cell_done;

    assign mem_addr = addr;
    assign progress = addr;

    always_comb begin
        in_cell  = state inside {START, DATA, STOP, LEADER};
        cell_bit = 1'b1;
        case (state)
            START:   cell_bit = 1'b0;
            DATA:    cell_bit = shreg[0];
            default: cell_bit = 1'b1;
        endcase
    end

    // Any abort or a fresh byte clears the cell so the next tick starts a clean high half.
    assign cell_start = rewind || loaded || (state == LATCH);

    tape_bitcell #(.HALF_W(HALF_W)) u_bitcell (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce_tape && in_cell),
        .hold      (pause),
        .start     (cell_start),
        .bit_val   (cell_bit),
        .one_half  (HALF_W'(ONE_HALF)),
        .zero_half (HALF_W'(ZERO_HALF)),
        .out       (out),
        .done      (cell_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            len      <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            req      <= 1'b0;
`ifdef TAPE_LEADER_EN
            leader_cnt <= '0;
`endif
        end else if (rewind) begin
            state <= IDLE;
            addr  <= '0;
            req   <= 1'b0;
        end else if (loaded) begin
            if (length != '0) begin
                len   <= length;
                addr  <= '0;
                req   <= 1'b1;
                state <= FIRST_STATE;
`ifdef TAPE_LEADER_EN
                leader_cnt <= '0;
`endif
            end else begin
                state <= IDLE;
                req   <= 1'b0;
            end
        end else begin
            case (state)
                FETCH: state <= LATCH;
                LATCH: begin
                    shreg <= mem_data;
                    state <= START;
                end
                START: if (cell_done) begin
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (cell_done) begin
                    shreg <= shreg >> 1;
                    if (bit_idx == 3'(BITS_PER_BYTE-1)) begin
                        stop_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: if (cell_done) begin
                    if (stop_cnt == 2'(STOP_BITS-1)) begin
                        if (addr == len - ADDR_W'(1)) begin
                            req   <= 1'b0;
                            state <= IDLE;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 2'd1;
                    end
                end
`ifdef TAPE_LEADER_EN
                LEADER: if (cell_done) begin
                    if (leader_cnt == 8'(LEADER_BITS-1)) state <= FETCH;
                    else leader_cnt <= leader_cnt + 8'd1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_player.sv
// tb/tb_tape_player.sv - scoreboard bench decoding the cassette waveform back into framed bytes
module tb_tape_player;

    localparam int ADDR_W    = 16;
    localparam int HALF_W    = 4;
    localparam int ONE_HALF  = 1;
    localparam int ZERO_HALF = 2;
    localparam int STOP_BITS = 2;
`ifdef TAPE_LEADER_EN
    localparam int EXP_LEADER = 256;
`else
    localparam int EXP_LEADER = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         ticks;
    } frame_t;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic              ce_tape = 1'b0;
    logic              loaded  = 1'b0;
    logic [ADDR_W-1:0] length  = '0;
    logic              pause   = 1'b0;
    logic              rewind  = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              req;
    logic              out;
    logic [ADDR_W-1:0] progress;

    logic [7:0] mem [0:255];
    logic [1:0] ce_div = 2'd0;

    int checks = 0;
    int errors = 0;
    frame_t exp_q[$];
    int addr_log[$];

    logic       mon_clear = 1'b0;
    logic       mon_tick;
    logic       frame_ok = 1'b1;
    logic [7:0] shv = '0;
    int high_run = 0, low_run = 0, prev_h = 0, fstate = 0, nbits = 0, nstop = 0, fticks = 0;
    int frames_done = 0, bits_seen = 0, leader_cells = 0;
    logic              req_prev = 1'b0;
    logic [ADDR_W-1:0] addr_prev = '0;

    tape_player #(
        .ADDR_W(ADDR_W), .HALF_W(HALF_W), .ONE_HALF(ONE_HALF),
        .ZERO_HALF(ZERO_HALF), .STOP_BITS(STOP_BITS)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_tape  (ce_tape),
        .loaded   (loaded),
        .length   (length),
        .pause    (pause),
        .rewind   (rewind),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .req      (req),
        .out      (out),
        .progress (progress)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        ce_div  = ce_div + 2'd1;
        ce_tape = (ce_div == 2'd0);
    end

    always @(posedge clk_sys) mem_data <= mem[mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int frame_ticks(input logic [7:0] b);
        int t;
        t = 2 * ZERO_HALF + STOP_BITS * 2 * ONE_HALF;
        for (int i = 0; i < 8; i++) t += b[i] ? 2 * ONE_HALF : 2 * ZERO_HALF;
        return t;
    endfunction

    task automatic push_exp(input logic [7:0] b);
        frame_t f;
        f.data  = b;
        f.ticks = frame_ticks(b);
        exp_q.push_back(f);
    endtask

    task automatic finish_frame();
        frame_t f;
        frames_done++;
        if (exp_q.size() == 0) begin
            check("frame_unexpected", exp_q.size(), 1);
        end else begin
            f = exp_q.pop_front();
            check("frame_byte", shv, f.data);
            check("frame_ticks", fticks, f.ticks);
            check("frame_cells", frame_ok, 1'b1);
        end
    endtask

    task automatic decode(input int h);
        logic good, b;
        good = (h == ONE_HALF) || (h == ZERO_HALF);
        b    = (h == ONE_HALF);
        bits_seen++;
        case (fstate)
            0: if (good && !b) begin
                fstate = 1; nbits = 0; shv = '0; frame_ok = 1'b1; fticks = 2 * h;
            end else if (good) begin
                leader_cells++;
            end
            1: begin
                shv = {b, shv[7:1]};
                nbits++;
                fticks += 2 * h;
                if (!good) frame_ok = 1'b0;
                if (nbits == 8) begin fstate = 2; nstop = 0; end
            end
            default: begin
                fticks += 2 * h;
                if (!good || !b) frame_ok = 1'b0;
                nstop++;
                if (nstop == STOP_BITS) begin finish_frame(); fstate = 0; end
            end
        endcase
    endtask

    // High-run length identifies each bit; low runs inside a frame must mirror the preceding high half.
    always @(posedge clk_sys) begin
        mon_tick = ce_tape && !pause;
        #1;
        if (mon_clear) begin
            high_run = 0; low_run = 0; fstate = 0;
        end else if (mon_tick) begin
            if (out) begin
                if (low_run != 0 && fstate != 0 && low_run != prev_h) frame_ok = 1'b0;
                low_run = 0;
                high_run++;
            end else begin
                if (high_run != 0) begin decode(high_run); prev_h = high_run; high_run = 0; end
                low_run++;
            end
        end
        if (req && (!req_prev || mem_addr != addr_prev)) addr_log.push_back(int'(mem_addr));
        req_prev  = req;
        addr_prev = mem_addr;
    end

    task automatic load(input int n);
        @(negedge clk_sys);
        loaded = 1'b1;
        length = ADDR_W'(n);
        @(negedge clk_sys);
        loaded = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 8000 && req; i++) @(negedge clk_sys);
        check(tag, req, 1'b0);
    endtask

    initial begin
        int base_frames, base_leader, base_bits, i;
        logic out_hold;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k * 7 + 3);
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'hA5;

        repeat (4) @(negedge clk_sys);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_req", req, 1'b0);
        check("rst_out", out, 1'b0);
        check("rst_progress", progress, 0);
        reset = 1'b0;

        // Three bytes with a pause placed inside the third frame.
        addr_log.delete();
        base_frames = frames_done;
        base_leader = leader_cells;
        push_exp(mem[0]); push_exp(mem[1]); push_exp(mem[2]);
        load(3);
        for (i = 0; i < 8000 && progress != 2; i++) @(negedge clk_sys);
        check("reach_byte2", progress, 2);
        repeat (40) @(negedge clk_sys);
        pause     = 1'b1;
        out_hold  = out;
        base_bits = bits_seen;
        repeat (200) @(negedge clk_sys);
        check("pause_out_frozen", out, out_hold);
        check("pause_bits_frozen", bits_seen, base_bits);
        check("pause_req_high", req, 1'b1);
        pause = 1'b0;
        wait_idle("play3_req_low");
        repeat (8) @(negedge clk_sys);
        check("play3_frames", frames_done - base_frames, 3);
        check("play3_queue_empty", exp_q.size(), 0);
        check("play3_out_low", out, 1'b0);
        check("play3_leader", leader_cells - base_leader, EXP_LEADER);
        check("addr_log_len", addr_log.size(), 3);
        for (int k = 0; k < addr_log.size() && k < 3; k++) check("addr_seq", addr_log[k], k);

        // Empty image: nothing starts, address stays at the last byte played.
        load(0);
        repeat (20) @(negedge clk_sys);
        check("empty_req", req, 1'b0);
        check("empty_out", out, 1'b0);
        check("empty_mem_addr", mem_addr, 2);

        // Rewind in the middle of byte 1, then replay from the start.
        base_frames = frames_done;
        push_exp(mem[0]);
        load(3);
        for (i = 0; i < 8000 && progress != 1; i++) @(negedge clk_sys);
        check("reach_byte1", progress, 1);
        repeat (40) @(negedge clk_sys);
        rewind    = 1'b1;
        mon_clear = 1'b1;
        @(negedge clk_sys);
        rewind = 1'b0;
        check("rewind_req", req, 1'b0);
        check("rewind_out", out, 1'b0);
        check("rewind_progress", progress, 0);
        check("rewind_frames", frames_done - base_frames, 1);
        @(negedge clk_sys);
        mon_clear = 1'b0;
        base_frames = frames_done;
        push_exp(mem[0]); push_exp(mem[1]); push_exp(mem[2]);
        load(3);
        wait_idle("replay_req_low");
        repeat (8) @(negedge clk_sys);
        check("replay_frames", frames_done - base_frames, 3);
        check("replay_queue_empty", exp_q.size(), 0);

        // Reset wins over a simultaneous load.
        @(negedge clk_sys);
        reset = 1'b1; loaded = 1'b1; length = ADDR_W'(3);
        @(negedge clk_sys);
        reset = 1'b0; loaded = 1'b0;
        check("rstld_req", req, 1'b0);
        check("rstld_out", out, 1'b0);
        check("rstld_mem_addr", mem_addr, 0);
        check("rstld_progress", progress, 0);
        repeat (20) @(negedge clk_sys);
        check("rstld_stays_idle", req, 1'b0);

        // Single-byte image exercises the leader (or its absence) and the length-1 stop.
        base_frames = frames_done;
        base_leader = leader_cells;
        push_exp(mem[0]);
        load(1);
        wait_idle("len1_req_low");
        repeat (8) @(negedge clk_sys);
        check("len1_frames", frames_done - base_frames, 1);
        check("len1_leader", leader_cells - base_leader, EXP_LEADER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
